// File: rtl/add_sub_accumulator.sv
// Two-stage pipelined adder/subtractor with valid/ready handshakes on both
// sides, signed/unsigned overflow detection, optional saturation and an
// internal running accumulator.
//
// Stage 1 holds the accepted operands. The output stage holds the computed
// result. The arithmetic is evaluated combinationally from stage 1 (and the
// accumulator) and is captured when a beat moves from stage 1 into the
// output stage. At most two beats are in flight at any time.
module add_sub_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int SIGNED     = 0,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic [1:0]            operation,
    input  logic                  clear_acc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  of_uf,
    output logic [DATA_WIDTH-1:0] acc_value
);

    typedef enum logic [1:0] {
        OP_SUB     = 2'b00,
        OP_ADD     = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } op_e;

    localparam int W = DATA_WIDTH;

    // Representable extremes used when saturating.
    localparam logic [W-1:0] MAX_U = {W{1'b1}};
    localparam logic [W-1:0] MIN_U = {W{1'b0}};
    localparam logic [W-1:0] MAX_S = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_S = {1'b1, {(W-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] s1_a_q,     s1_a_d;
    logic [W-1:0] s1_b_q,     s1_b_d;
    op_e          s1_op_q,    s1_op_d;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] result_q,    result_d;
    logic         of_uf_q,     of_uf_d;

    logic [W-1:0] acc_q,       acc_d;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic out_load;   // output stage may take a new beat this cycle
    logic accept;     // input beat enters stage 1
    logic xfer;       // stage 1 beat moves into the output stage

    assign out_load = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || out_load;
    assign accept   = in_valid && in_ready;
    assign xfer     = s1_valid_q && out_load;

    // ------------------------------------------------------------------
    // Arithmetic on the stage 1 beat
    // ------------------------------------------------------------------
    logic         is_acc;
    logic         is_sub;
    logic [W-1:0] lhs;
    logic [W-1:0] rhs;
    logic [W:0]   wide;
    logic [W-1:0] raw;
    logic         same_sign;
    logic         ovf;
    logic [W-1:0] sat_val;
    logic [W-1:0] calc_res;

    // Compute the W+1-bit result, the overflow flag and the final value.
    always_comb begin
        // NOTE: every signal written here gets a value before any branch so no latch is inferred.
        is_acc    = (s1_op_q == OP_ACC_ADD) || (s1_op_q == OP_ACC_SUB);
        is_sub    = (s1_op_q == OP_SUB)     || (s1_op_q == OP_ACC_SUB);
        lhs       = is_acc ? acc_q  : s1_a_q;
        rhs       = is_acc ? s1_a_q : s1_b_q;
        wide      = is_sub ? ({1'b0, lhs} - {1'b0, rhs})
                           : ({1'b0, lhs} + {1'b0, rhs});
        raw       = wide[W-1:0];
        same_sign = (lhs[W-1] == rhs[W-1]);
        ovf       = 1'b0;
        sat_val   = raw;

        if (SIGNED != 0) begin
            // Add overflows when like signs yield a different sign; subtract
            // overflows when unlike signs yield a sign differing from the
            // minuend. Either way the true result lies on the minuend's side.
            ovf     = (is_sub ? !same_sign : same_sign) && (raw[W-1] != lhs[W-1]);
            sat_val = lhs[W-1] ? MIN_S : MAX_S;
        end else begin
            // Extra bit is carry-out for add and borrow for subtract.
            ovf     = wide[W];
            sat_val = is_sub ? MIN_U : MAX_U;
        end

        calc_res = ((SATURATE != 0) && ovf) ? sat_val : raw;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Stage 1: load on accept, empty when its beat moves on.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;

        if (xfer) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = operand_a;
            s1_b_d     = operand_b;
            s1_op_d    = op_e'(operation);
        end
    end

    // Output stage: capture on transfer, hold while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        of_uf_d     = of_uf_q;

        if (out_load) begin
            out_valid_d = s1_valid_q;
        end
        if (xfer) begin
            result_d = calc_res;
            of_uf_d  = ovf;
        end
    end

    // Accumulator: ACC ops write their final result; clear has priority but
    // the transferring op has already used the pre-clear value above.
    always_comb begin
        acc_d = acc_q;
        if (clear_acc) begin
            acc_d = '0;
        end else if (xfer && is_acc) begin
            acc_d = calc_res;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // State update with synchronous reset discarding all in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: stage 1 data is cleared too, so nothing undefined can reach
            // the arithmetic or the accumulator after reset.
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= OP_SUB;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            of_uf_q     <= 1'b0;
            acc_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            of_uf_q     <= of_uf_d;
            acc_q       <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign of_uf     = of_uf_q;
    assign acc_value = acc_q;

endmodule

// File: tb/tb_add_sub_accumulator.sv
// Bench for add_sub_accumulator. Three instances share one stimulus stream:
//   cfg 0: unsigned, wrap   cfg 1: unsigned, saturate   cfg 2: signed, saturate
// A queue-based reference model computes results with plain integer
// arithmetic; directed steps also check the hand-computed values.
module tb_add_sub_accumulator;

    localparam int W = 8;

    localparam logic [1:0] SUB     = 2'b00;
    localparam logic [1:0] ADD     = 2'b01;
    localparam logic [1:0] ACC_ADD = 2'b10;
    localparam logic [1:0] ACC_SUB = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic [1:0]   operation = '0;
    logic         clear_acc = 1'b0;
    logic         out_ready = 1'b0;

    logic         in_ready_w  [3];
    logic         out_valid_w [3];
    logic         of_uf_w     [3];
    logic [W-1:0] result_w    [3];
    logic [W-1:0] acc_w       [3];

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    add_sub_accumulator #(.DATA_WIDTH(W), .SIGNED(0), .SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .operand_a(operand_a), .operand_b(operand_b), .operation(operation),
        .clear_acc(clear_acc), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .result(result_w[0]), .of_uf(of_uf_w[0]), .acc_value(acc_w[0]));

    add_sub_accumulator #(.DATA_WIDTH(W), .SIGNED(0), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .operand_a(operand_a), .operand_b(operand_b), .operation(operation),
        .clear_acc(clear_acc), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .result(result_w[1]), .of_uf(of_uf_w[1]), .acc_value(acc_w[1]));

    add_sub_accumulator #(.DATA_WIDTH(W), .SIGNED(1), .SATURATE(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .operand_a(operand_a), .operand_b(operand_b), .operation(operation),
        .clear_acc(clear_acc), .out_valid(out_valid_w[2]), .out_ready(out_ready),
        .result(result_w[2]), .of_uf(of_uf_w[2]), .acc_value(acc_w[2]));

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0]        op;
        logic [W-1:0]      a;
        logic [W-1:0]      b;
        logic              presented;
        logic [2:0][W-1:0] res;
        logic [2:0]        fl;
    } beat_t;

    beat_t        held[$];      // beats inside the block, oldest first
    logic [W-1:0] acc_m [3];
    bit           model_live = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_op(input int cfg, input logic [1:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] acc,
                                   output logic [W-1:0] res, output logic fl);
        logic [W-1:0] lhs, rhs;
        int l, r, x, lo, hi;
        lhs = op[1] ? acc : a;
        rhs = op[1] ? a   : b;
        if (cfg == 2) begin
            l = int'($signed(lhs)); r = int'($signed(rhs)); lo = -128; hi = 127;
        end else begin
            l = int'(lhs); r = int'(rhs); lo = 0; hi = 255;
        end
        x  = (op == SUB || op == ACC_SUB) ? (l - r) : (l + r);
        fl = (x > hi) || (x < lo);
        if (fl && cfg != 0) res = (x > hi) ? hi[W-1:0] : lo[W-1:0];
        else                res = x[W-1:0];
    endfunction

    function automatic bit front_presented();
        return (held.size() > 0) && held[0].presented;
    endfunction

    function automatic bit s1_full();
        return (held.size() == 2) || (held.size() == 1 && !held[0].presented);
    endfunction

    // Compare all instances with the model state before the coming edge.
    task automatic compare_all();
        bit fp, rdy;
        fp  = front_presented();
        rdy = !s1_full() || !fp || out_ready;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("c%0d in_ready", c), 32'(in_ready_w[c]), 32'(rdy));
            check($sformatf("c%0d out_valid", c), 32'(out_valid_w[c]), 32'(fp));
            if (fp) begin
                check($sformatf("c%0d result", c), 32'(result_w[c]), 32'(held[0].res[c]));
                check($sformatf("c%0d of_uf", c), 32'(of_uf_w[c]), 32'(held[0].fl[c]));
            end
            check($sformatf("c%0d acc_value", c), 32'(acc_w[c]), 32'(acc_m[c]));
        end
    endtask

    // Advance the model across one rising edge.
    task automatic model_edge();
        bit fp, free, full, rdy;
        beat_t bt;
        logic [W-1:0] r8;
        logic f;
        if (rst) begin
            held.delete();
            for (int c = 0; c < 3; c++) acc_m[c] = '0;
            model_live = 1'b1;
            return;
        end
        fp   = front_presented();
        free = !fp || out_ready;
        full = s1_full();
        rdy  = !full || free;
        if (free && fp) void'(held.pop_front());
        if (free && full) begin
            bt = held[0];
            for (int c = 0; c < 3; c++) begin
                ref_op(c, bt.op, bt.a, bt.b, acc_m[c], r8, f);
                bt.res[c] = r8;
                bt.fl[c]  = f;
                if (bt.op[1]) acc_m[c] = r8;
            end
            bt.presented = 1'b1;
            held[0] = bt;
        end
        if (clear_acc) for (int c = 0; c < 3; c++) acc_m[c] = '0;
        if (in_valid && rdy) begin
            bt = '0;
            bt.op = operation; bt.a = operand_a; bt.b = operand_b;
            held.push_back(bt);
        end
    endtask

    // One clock cycle: drive on the falling edge, check, then cross the edge.
    task automatic step(input bit r, input bit v, input logic [1:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit clr, input bit ordy);
        @(negedge clk);
        rst = r; in_valid = v; operation = o; operand_a = a; operand_b = b;
        clear_acc = clr; out_ready = ordy;
        #1;
        if (model_live) compare_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 1'b0, ADD, '0, '0, 1'b0, ordy);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset
        step(1'b1, 1'b0, ADD, '0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b1, ADD, 8'd1, 8'd1, 1'b0, 1'b1);
        in_valid = 1'b0; rst = 1'b0; #1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("rst c%0d out_valid", c), 32'(out_valid_w[c]), 32'd0);
            check($sformatf("rst c%0d result", c), 32'(result_w[c]), 32'd0);
            check($sformatf("rst c%0d of_uf", c), 32'(of_uf_w[c]), 32'd0);
            check($sformatf("rst c%0d acc", c), 32'(acc_w[c]), 32'd0);
            check($sformatf("rst c%0d in_ready", c), 32'(in_ready_w[c]), 32'd1);
        end

        // Unsigned wrap: ADD 200+100, out_valid after the second edge
        step(1'b0, 1'b1, ADD, 8'd200, 8'd100, 1'b0, 1'b1);
        check("add200+100 latency", 32'(out_valid_w[0]), 32'd0);
        idle(1'b1);
        check("add200+100 valid", 32'(out_valid_w[0]), 32'd1);
        check("add200+100 res", 32'(result_w[0]), 32'h2C);
        check("add200+100 flag", 32'(of_uf_w[0]), 32'd1);
        check("add200+100 sat", 32'(result_w[1]), 32'hFF);

        step(1'b0, 1'b1, SUB, 8'd10, 8'd5, 1'b0, 1'b1);
        idle(1'b1);
        check("sub10-5 res", 32'(result_w[0]), 32'd5);
        check("sub10-5 flag", 32'(of_uf_w[0]), 32'd0);

        // Saturation
        step(1'b0, 1'b1, SUB, 8'd5, 8'd10, 1'b0, 1'b1);
        idle(1'b1);
        check("usat sub5-10 res", 32'(result_w[1]), 32'h00);
        check("usat sub5-10 flag", 32'(of_uf_w[1]), 32'd1);

        step(1'b0, 1'b1, ADD, 8'd100, 8'd100, 1'b0, 1'b1);
        idle(1'b1);
        check("ssat 100+100 res", 32'(result_w[2]), 32'h7F);
        check("ssat 100+100 flag", 32'(of_uf_w[2]), 32'd1);

        step(1'b0, 1'b1, ADD, 8'h9C, 8'h9C, 1'b0, 1'b1);
        idle(1'b1);
        check("ssat -100-100 res", 32'(result_w[2]), 32'h80);
        check("ssat -100-100 flag", 32'(of_uf_w[2]), 32'd1);

        step(1'b0, 1'b1, ADD, 8'd50, 8'hEC, 1'b0, 1'b1);
        idle(1'b1);
        check("ssat 50-20 res", 32'(result_w[2]), 32'd30);
        check("ssat 50-20 flag", 32'(of_uf_w[2]), 32'd0);

        // Accumulate back-to-back
        step(1'b0, 1'b0, ADD, '0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b1, ACC_ADD, 8'd10, 8'd0, 1'b0, 1'b1);
        step(1'b0, 1'b1, ACC_ADD, 8'd20, 8'd0, 1'b0, 1'b1);
        check("acc +10", 32'(result_w[0]), 32'd10);
        step(1'b0, 1'b1, ACC_ADD, 8'd30, 8'd0, 1'b0, 1'b1);
        check("acc +20", 32'(result_w[0]), 32'd30);
        idle(1'b1);
        check("acc +30", 32'(result_w[0]), 32'd60);
        check("acc value 60", 32'(acc_w[0]), 32'd60);
        step(1'b0, 1'b1, ACC_SUB, 8'd70, 8'd0, 1'b0, 1'b1);
        idle(1'b1);
        check("acc -70 res", 32'(result_w[0]), 32'hF6);
        check("acc -70 flag", 32'(of_uf_w[0]), 32'd1);
        idle(1'b1);

        // Backpressure
        step(1'b0, 1'b1, ADD, 8'd1, 8'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, ADD, 8'd2, 8'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, ADD, 8'd3, 8'd3, 1'b0, 1'b0);
        check("bp in_ready low", 32'(in_ready_w[0]), 32'd0);
        check("bp hold 2", 32'(result_w[0]), 32'd2);
        step(1'b0, 1'b1, ADD, 8'd3, 8'd3, 1'b0, 1'b0);
        check("bp still 2", 32'(result_w[0]), 32'd2);
        check("bp still valid", 32'(out_valid_w[0]), 32'd1);
        step(1'b0, 1'b1, ADD, 8'd3, 8'd3, 1'b0, 1'b1);
        check("bp drain 4", 32'(result_w[0]), 32'd4);
        idle(1'b1);
        check("bp drain 6", 32'(result_w[0]), 32'd6);
        idle(1'b1);
        check("bp empty", 32'(out_valid_w[0]), 32'd0);

        // clear_acc colliding with an ACC transfer
        step(1'b0, 1'b0, ADD, '0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b1, ACC_ADD, 8'd60, 8'd0, 1'b0, 1'b1);
        idle(1'b1);
        step(1'b0, 1'b1, ACC_ADD, 8'd5, 8'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, ADD, '0, '0, 1'b1, 1'b1);
        check("collide res", 32'(result_w[0]), 32'd65);
        check("collide acc", 32'(acc_w[0]), 32'd0);
        step(1'b0, 1'b1, ACC_ADD, 8'd7, 8'd0, 1'b0, 1'b1);
        idle(1'b1);
        check("after clear +7", 32'(result_w[0]), 32'd7);

        // Reset with two beats in flight
        step(1'b0, 1'b1, ADD, 8'd9, 8'd9, 1'b0, 1'b0);
        step(1'b0, 1'b1, ADD, 8'd8, 8'd8, 1'b0, 1'b0);
        step(1'b1, 1'b1, ADD, 8'd5, 8'd5, 1'b0, 1'b0);
        check("midrst out_valid", 32'(out_valid_w[0]), 32'd0);
        check("midrst acc", 32'(acc_w[0]), 32'd0);
        check("midrst result", 32'(result_w[0]), 32'd0);
        check("midrst of_uf", 32'(of_uf_w[0]), 32'd0);
        idle(1'b1);
        idle(1'b1);
        check("midrst no stale", 32'(out_valid_w[0]), 32'd0);
        step(1'b0, 1'b1, ADD, 8'd3, 8'd4, 1'b0, 1'b1);
        idle(1'b1);
        check("midrst add3+4", 32'(result_w[0]), 32'd7);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
